// File: rtl/clip_pkg.sv
// Shared types and constants for the clip record/playback sequencer.
package clip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MEMSEL_WRITE_BIT = 0;
    localparam int MEMSEL_BLOCK_BIT = 1;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_SAMPLE_HZ    = 8_000;
    localparam int DEF_CLIP_SECONDS = 2;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: tick is high on the terminal count, once every CLK_HZ/SAMPLE_HZ cycles.
module sample_tick_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 8_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clear && (r_cnt == TERM);

endmodule

// File: rtl/clip_memory_sequencer.sv
// Steps one clip of sample-rate addresses through the two-block sample RAM,
// recording ADC samples or playing them back to the DAC, then flags completion.
module clip_memory_sequencer
    import clip_pkg::*;
#(
    parameter  int CLK_HZ       = DEF_CLK_HZ,
    parameter  int SAMPLE_HZ    = DEF_SAMPLE_HZ,
    parameter  int CLIP_SECONDS = DEF_CLIP_SECONDS,
    parameter  int DATA_W       = 16,
    localparam int SAMPLES      = SAMPLE_HZ * CLIP_SECONDS,
    localparam int IDX_W        = $clog2(SAMPLES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              timer,
    input  logic [1:0]        memsel,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W:0]    mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              seconds2,
    output logic              busy,
    output state_t            dbg_state
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_hold;
    logic              r_final;
    logic              r_rd_issue;
    logic              r_rd_capture;
    logic [IDX_W:0]    r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_dac_data;
    logic              r_dac_valid;

    logic w_tick;
    logic w_clear;
    logic w_write;
    logic w_service;

    assign w_clear   = (r_state != RUN);
    assign w_write   = r_op[MEMSEL_WRITE_BIT];
    assign w_service = (r_state == RUN) && timer && w_tick && !r_final;

    sample_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .SAMPLE_HZ(SAMPLE_HZ)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(w_clear),
        .tick (w_tick)
    );

    // After the last tick, RUN is held until that sample's access has drained:
    // the write strobe for record, the read data capture for play.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (timer) w_next = RUN;
            RUN: begin
                if (!timer) begin
                    w_next = IDLE;
                end else if (r_final && (w_write || (!r_rd_issue && r_rd_capture))) begin
                    w_next = DONE;
                end
            end
            DONE: if (!timer) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_final      <= 1'b0;
            r_rd_issue   <= 1'b0;
            r_rd_capture <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_dac_data   <= '0;
            r_dac_valid  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_we        <= 1'b0;
            r_dac_valid <= 1'b0;
            r_rd_issue  <= 1'b0;
            // Reads still in the pipe are dropped when the operation is abandoned.
            r_rd_capture <= r_rd_issue && (w_next != IDLE);
            if (adc_valid) begin
                r_hold <= adc_data;
            end
            if (r_rd_capture && (w_next != IDLE)) begin
                r_dac_data  <= mem_rdata;
                r_dac_valid <= 1'b1;
            end
            if (r_state == IDLE && timer) begin
                r_op    <= memsel;
                r_idx   <= '0;
                r_final <= 1'b0;
            end
            if (w_service) begin
                r_addr <= {r_op[MEMSEL_BLOCK_BIT], r_idx};
                if (w_write) begin
                    r_we    <= 1'b1;
                    r_wdata <= r_hold;
                end else begin
                    r_rd_issue <= 1'b1;
                end
                if (r_idx == LAST_IDX) begin
                    r_final <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;
    assign dac_data  = r_dac_data;
    assign dac_valid = r_dac_valid;
    assign seconds2  = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clip_memory_sequencer.sv
// Bench for clip_memory_sequencer with an 8-word sample RAM model and a
// cycle-indexed reference of when each write / playback sample must appear.
module tb_clip_memory_sequencer;
    import clip_pkg::*;

    localparam int DIV = 4;
    localparam int S   = 4;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int NO_LIMIT = 1_000_000;

    logic          clock = 1'b0;
    logic          reset;
    logic          timer;
    logic [1:0]    memsel;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic          seconds2;
    logic          busy;
    state_t        dbg_state;

    logic [DW-1:0]    ram [8];
    logic [DW-1:0]    ref_mem [8];
    logic             pre_we;
    logic [AW-1:0]    pre_addr;
    logic [DW-1:0]    pre_data;
    logic [DW-1:0]    smp [S];
    logic [AW+DW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    clip_memory_sequencer #(
        .CLK_HZ(8), .SAMPLE_HZ(2), .CLIP_SECONDS(2), .DATA_W(DW)
    ) dut (
        .clock(clock), .reset(reset), .timer(timer), .memsel(memsel),
        .adc_data(adc_data), .adc_valid(adc_valid), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .dac_data(dac_data), .dac_valid(dac_valid), .seconds2(seconds2),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    // Synchronous-read sample RAM: data appears one cycle after the address.
    always @(posedge clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Runs one clip operation. Cycle i counts from the first RUN cycle.
    // limit is the last cycle before abort/reset takes effect.
    task automatic run_op(input string tag, input logic blk, input logic wr,
                          input int abort_at, input int reset_at, input bit toggle);
        int limit, done_start, sample_cyc[S], k;
        logic exp_we, exp_dv, exp_s2, exp_busy;
        logic [AW-1:0] a;
        logic [AW+DW-1:0] e;
        limit = NO_LIMIT;
        if (abort_at >= 0) limit = abort_at;
        if (reset_at >= 0 && reset_at < limit) limit = reset_at;
        done_start = wr ? DIV*S + 1 : DIV*S + 2;
        exp_q.delete();
        for (int j = 0; j < S; j++) begin
            sample_cyc[j] = DIV*j + $urandom_range(0, DIV-2);
            if (wr && DIV*(j+1) <= limit) begin
                a = {blk, j[1:0]};
                exp_q.push_back({a, smp[j]});
                ref_mem[a] = smp[j];
            end
        end
        @(negedge clock);
        timer = 1'b1; memsel = {blk, wr};
        for (int i = 0; i <= DIV*S + 6; i++) begin
            @(negedge clock);
            exp_busy = (i < done_start) && (i <= limit);
            exp_s2   = (limit == NO_LIMIT) && (i >= done_start);
            exp_we   = wr && (i >= DIV) && (i % DIV == 0) && (i <= DIV*S) && (i <= limit);
            exp_dv   = !wr && (i - 2 >= DIV) && ((i - 2) % DIV == 0) && (i - 2 <= DIV*S) && (i <= limit);
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, i, busy, exp_busy);
            end
            n_tests++;
            if (seconds2 !== exp_s2) begin
                n_fail++; $display("FAIL %s seconds2 cyc=%0d got=%b exp=%b", tag, i, seconds2, exp_s2);
            end
            n_tests++;
            if (mem_we !== exp_we) begin
                n_fail++; $display("FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, i, mem_we, exp_we);
            end
            if (mem_we === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL %s extra_write cyc=%0d got addr=%0d data=%h exp none", tag, i, mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        n_fail++; $display("FAIL %s write cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                           tag, i, mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            n_tests++;
            if (dac_valid !== exp_dv) begin
                n_fail++; $display("FAIL %s dac_valid cyc=%0d got=%b exp=%b", tag, i, dac_valid, exp_dv);
            end
            if (exp_dv) begin
                k = (i - 2) / DIV - 1;
                a = {blk, k[1:0]};
                n_tests++;
                if (dac_data !== ref_mem[a]) begin
                    n_fail++; $display("FAIL %s dac_data cyc=%0d got=%h exp=%h", tag, i, dac_data, ref_mem[a]);
                end
            end
            if (reset_at >= 0 && i == reset_at + 1) begin
                n_tests++;
                if (mem_addr !== '0 || dac_data !== '0) begin
                    n_fail++; $display("FAIL %s reset_regs got addr=%0d dac=%h exp 0", tag, mem_addr, dac_data);
                end
            end
            adc_valid = 1'b0;
            for (int j = 0; j < S; j++) begin
                if (wr && i == sample_cyc[j]) begin
                    adc_valid = 1'b1; adc_data = smp[j];
                end
            end
            if (i == abort_at) timer = 1'b0;
            if (i == reset_at) reset = 1'b1;
            if (toggle && i == 5) memsel = 2'b11;
        end
        adc_valid = 1'b0; reset = 1'b0; timer = 1'b0;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || seconds2 !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL %s end_idle got busy=%b s2=%b st=%0d exp 0 0 IDLE", tag, busy, seconds2, dbg_state);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s missing_writes got %0d outstanding exp 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; timer = 1'b1; memsel = 2'b01;
        adc_valid = 1'b0; adc_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_tests++;
            if ({mem_addr, mem_we, mem_wdata, dac_data, dac_valid, seconds2, busy} !== '0
                || dbg_state !== IDLE) begin
                n_fail++; $display("FAIL reset outputs cyc=%0d got we=%b addr=%0d busy=%b s2=%b st=%0d exp all 0 IDLE",
                                   i, mem_we, mem_addr, busy, seconds2, dbg_state);
            end
        end
        timer = 1'b0; reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_record_block1();
        smp[0] = 16'h00A1; smp[1] = 16'h00B2; smp[2] = 16'h00C3; smp[3] = 16'h00D4;
        run_op("record_b1", 1'b1, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_play_block0();
        for (int j = 0; j < S; j++) preload(AW'(j), DW'(16'h11 * (j + 1)));
        run_op("play_b0", 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_memsel_ignored();
        for (int j = 0; j < S; j++) smp[j] = DW'($urandom);
        run_op("memsel_toggle", 1'b0, 1'b1, -1, -1, 1'b1);
        run_op("play_back_b0", 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int j = 0; j < S; j++) preload(AW'(j), 16'hDEAD);
        for (int j = 0; j < S; j++) smp[j] = DW'($urandom);
        run_op("abort", 1'b0, 1'b1, 2*DIV, -1, 1'b0);
        run_op("abort_check", 1'b0, 1'b0, -1, -1, 1'b0);
        for (int j = 0; j < S; j++) smp[j] = DW'($urandom);
        run_op("restart", 1'b0, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < S; j++) preload(AW'(4 + j), DW'($urandom));
        run_op("play_b1", 1'b1, 1'b0, -1, -1, 1'b0);
        for (int j = 0; j < S; j++) smp[j] = DW'($urandom);
        run_op("record_b1_rand", 1'b1, 1'b1, -1, -1, 1'b0);
        run_op("play_b1_again", 1'b1, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_play();
        run_op("reset_mid_play", 1'b0, 1'b0, -1, DIV + 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_record_block1();
        test_play_block0();
        test_memsel_ignored();
        test_abort();
        test_back_to_back();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
